// File: rtl/motor_pkg.sv
// Shared motor-control types: commutation FSM states and Hall code decoding.
package motor_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_STALL
    } state_t;

    localparam logic [2:0] IDX_INVALID = 3'd7;
    localparam logic [2:0] N_SECTORS   = 3'd6;

    // Forward sequence 1,3,2,6,4,5 maps to sectors 0..5; codes 0 and 7 are impossible.
    function automatic logic [2:0] hall_to_idx(input logic [2:0] code);
        case (code)
            3'd1:    return 3'd0;
            3'd3:    return 3'd1;
            3'd2:    return 3'd2;
            3'd6:    return 3'd3;
            3'd4:    return 3'd4;
            3'd5:    return 3'd5;
            default: return IDX_INVALID;
        endcase
    endfunction

    function automatic logic [2:0] idx_next(input logic [2:0] idx);
        return (idx == N_SECTORS - 3'd1) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [2:0] idx_prev(input logic [2:0] idx);
        return (idx == 3'd0) ? N_SECTORS - 3'd1 : idx - 3'd1;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchroniser and debounce for the Hall lines; strobes accept for one
// cycle when a new code has been stable long enough.
module hall_filter #(
    parameter int K_FILTWIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             hall,
    input  logic [K_FILTWIDTH-1:0] param_filter,
    output logic [2:0]             code,
    output logic                   accept
);

    logic [2:0]             sync1;
    logic [2:0]             sync2;
    logic [2:0]             cand;
    logic [2:0]             acc_code;
    logic [K_FILTWIDTH-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            acc_code <= '0;
            cnt      <= '0;
        end else begin
            sync1 <= hall;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                acc_code <= cand;
            end
        end
    end

    // Comparing with >= lets a lowered filter setting take effect on a code already being counted.
    assign accept = (sync2 == cand) && (cnt >= param_filter) && (cand != acc_code);
    assign code   = cand;

endmodule

// File: rtl/hall_step_detect.sv
// Hall sensor step decoder: sequence check, step pulse, period, direction, stall and fault.
// Optional macro HALL_STEP_REVERSE_EN accepts reverse steps; otherwise they are faults.
module hall_step_detect
    import motor_pkg::*;
#(
    parameter int K_BUFWIDTH  = 13,
    parameter int K_FILTWIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [2:0]             i_hall,
    input  logic [K_FILTWIDTH-1:0] i_param_filter,
    input  logic                   i_clear_err,
    output logic                   o_next_step,
    output logic [2:0]             o_step_idx,
    output logic                   o_dir,
    output logic [K_BUFWIDTH-1:0]  o_step_period,
    output logic                   o_stall,
    output logic                   o_err
);

    localparam logic [K_BUFWIDTH-1:0] PERIOD_MAX = '1;

    state_t                state;
    logic [K_BUFWIDTH-1:0] period_cnt;
    logic [2:0]            code;
    logic                  accept;
    logic [2:0]            new_idx;
    logic                  is_fwd;
    logic                  is_rev;
    logic                  sat;

    hall_filter #(
        .K_FILTWIDTH(K_FILTWIDTH)
    ) u_filter (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .hall        (i_hall),
        .param_filter(i_param_filter),
        .code        (code),
        .accept      (accept)
    );

    assign new_idx = hall_to_idx(code);
    assign is_fwd  = (new_idx == idx_next(o_step_idx));
    assign sat     = (period_cnt == PERIOD_MAX);

`ifdef HALL_STEP_REVERSE_EN
    logic dir;

    assign is_rev = (new_idx == idx_prev(o_step_idx));
    assign o_dir  = dir;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir <= 1'b1;
        end else if (accept && state != S_INIT && new_idx != IDX_INVALID && (is_fwd || is_rev)) begin
            dir <= is_fwd;
        end
    end
`else
    assign is_rev = 1'b0;
    assign o_dir  = 1'b1;
`endif

    // Faults are assigned after the clear, so a fault in the same cycle keeps o_err set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_INIT;
            period_cnt    <= '0;
            o_next_step   <= 1'b0;
            o_step_idx    <= 3'd0;
            o_step_period <= PERIOD_MAX;
            o_stall       <= 1'b1;
            o_err         <= 1'b0;
        end else begin
            o_next_step <= 1'b0;
            if (!sat) begin
                period_cnt <= period_cnt + 1'b1;
            end
            if (i_clear_err) begin
                o_err <= 1'b0;
            end

            if (accept) begin
                if (new_idx == IDX_INVALID) begin
                    o_err   <= 1'b1;
                    state   <= S_INIT;
                    o_stall <= 1'b1;
                end else if (state == S_INIT) begin
                    o_step_idx <= new_idx;
                    state      <= S_STALL;
                    o_stall    <= 1'b1;
                end else if (is_fwd || is_rev) begin
                    o_next_step <= 1'b1;
                    o_step_idx  <= new_idx;
                    period_cnt  <= K_BUFWIDTH'(1);
                    // A saturated counter means the last interval is meaningless; keep the old period.
                    if (state == S_RUN && !sat) begin
                        o_step_period <= period_cnt;
                    end
                    state   <= S_RUN;
                    o_stall <= 1'b0;
                end else begin
                    o_err      <= 1'b1;
                    o_step_idx <= new_idx;
                    state      <= S_STALL;
                    o_stall    <= 1'b1;
                end
            end else if (sat && state == S_RUN) begin
                state   <= S_STALL;
                o_stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hall_step_detect.sv
// Directed self-checking bench for hall_step_detect; inputs driven and outputs
// sampled on the falling clock edge.
module tb_hall_step_detect;

    localparam int BW   = 13;
    localparam int FW   = 4;
    localparam int PMAX = (1 << BW) - 1;

    logic          clk;
    logic          rst_n;
    logic [2:0]    hall;
    logic [FW-1:0] filt;
    logic          clear_err;
    logic          next_step;
    logic [2:0]    step_idx;
    logic          dir;
    logic [BW-1:0] step_period;
    logic          stall;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;
    int doubles  = 0;

    hall_step_detect #(
        .K_BUFWIDTH (BW),
        .K_FILTWIDTH(FW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_hall        (hall),
        .i_param_filter(filt),
        .i_clear_err   (clear_err),
        .o_next_step   (next_step),
        .o_step_idx    (step_idx),
        .o_dir         (dir),
        .o_step_period (step_period),
        .o_stall       (stall),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n falling edges, counting step pulses and back-to-back pulses.
    task automatic cyc(input int n, output int pulses);
        logic prev;
        prev   = 1'b0;
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (next_step) begin
                pulses++;
                if (prev) doubles++;
            end
            prev = next_step;
        end
    endtask

    task automatic step(input logic [2:0] code, input int n, output int pulses);
        hall = code;
        cyc(n, pulses);
    endtask

    task automatic do_reset();
        int p;
        rst_n = 1'b0;
        cyc(3, p);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pulse"},  32'(next_step),   32'd0);
        check({tag, "_idx"},    32'(step_idx),    32'd0);
        check({tag, "_dir"},    32'(dir),         32'd1);
        check({tag, "_period"}, 32'(step_period), PMAX);
        check({tag, "_stall"},  32'(stall),       32'd1);
        check({tag, "_err"},    32'(err),         32'd0);
    endtask

    initial begin
        int p;
        int p2;
        logic [2:0] fwd_seq [7];
        fwd_seq = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5, 3'd1};

        hall      = 3'd0;
        filt      = '0;
        clear_err = 1'b0;
        rst_n     = 1'b0;
        cyc(2, p);
        check_reset_values("rst");
        rst_n = 1'b1;

        // First valid code only loads the sector; next one pulses after 4 edges.
        step(3'd1, 10, p);
        check("init_pulses", 32'(p), 32'd0);
        check("init_idx", 32'(step_idx), 32'd0);
        check("init_stall", 32'(stall), 32'd1);
        step(3'd3, 3, p);
        check("lat_early", 32'(p), 32'd0);
        cyc(1, p);
        check("lat_pulse", 32'(p), 32'd1);
        check("lat_dir", 32'(dir), 32'd1);
        check("lat_idx", 32'(step_idx), 32'd1);
        check("lat_period", 32'(step_period), PMAX);
        check("lat_stall", 32'(stall), 32'd0);
        cyc(1, p);
        check("lat_single", 32'(p), 32'd0);

        // Forward rotation, 1000 cycles per sector, filter 2.
        do_reset();
        filt = 4'd2;
        for (int j = 0; j < 7; j++) begin
            step(fwd_seq[j], 1000, p);
            check($sformatf("rot%0d_pulses", j), 32'(p), (j == 0) ? 32'd0 : 32'd1);
            check($sformatf("rot%0d_period", j), 32'(step_period), (j < 2) ? PMAX : 32'd1000);
            check($sformatf("rot%0d_idx", j), 32'(step_idx), 32'(j % 6));
        end
        check("rot_err", 32'(err), 32'd0);
        check("rot_dir", 32'(dir), 32'd1);

        // Glitch 3->2->3: rejected with filter 4, accepted as two codes with filter 0.
        step(3'd3, 20, p);
        check("pre_glitch_pulse", 32'(p), 32'd1);
        filt = 4'd4;
        step(3'd2, 3, p);
        step(3'd3, 30, p2);
        check("glitch_f4_pulses", 32'(p + p2), 32'd0);
        check("glitch_f4_err", 32'(err), 32'd0);
        check("glitch_f4_idx", 32'(step_idx), 32'd1);
        filt = 4'd0;
        step(3'd2, 3, p);
        step(3'd3, 30, p2);
`ifdef HALL_STEP_REVERSE_EN
        check("glitch_f0_pulses", 32'(p + p2), 32'd2);
        check("glitch_f0_err", 32'(err), 32'd0);
        check("glitch_f0_dir", 32'(dir), 32'd0);
`else
        check("glitch_f0_pulses", 32'(p + p2), 32'd1);
        check("glitch_f0_err", 32'(err), 32'd1);
        check("glitch_f0_stall", 32'(stall), 32'd1);
`endif
        check("glitch_f0_idx", 32'(step_idx), 32'd1);

        // Invalid code with clear held: the fault edge wins over the clear.
        clear_err = 1'b1;
        step(3'd7, 3, p);
        check("inv_pre_err", 32'(err), 32'd0);
        cyc(1, p2);
        clear_err = 1'b0;
        check("inv_err_wins", 32'(err), 32'd1);
        cyc(6, p2);
        check("inv_pulses", 32'(p + p2), 32'd0);
        check("inv_stall", 32'(stall), 32'd1);
        check("inv_idx_held", 32'(step_idx), 32'd1);
        clear_err = 1'b1;
        step(3'd5, 10, p);
        clear_err = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        check("clr_idx", 32'(step_idx), 32'd5);
        check("clr_pulses", 32'(p), 32'd0);
        check("clr_stall", 32'(stall), 32'd1);
        step(3'd1, 10, p);
        check("reload_pulses", 32'(p), 32'd1);
        check("reload_idx", 32'(step_idx), 32'd0);
        check("reload_stall", 32'(stall), 32'd0);
        check("reload_dir", 32'(dir), 32'd1);

        // Fixed 10-cycle steps, then a skip 1->2, then saturation.
        do_reset();
        for (int j = 0; j < 7; j++) begin
            step(fwd_seq[j], 10, p);
        end
        check("fast_period", 32'(step_period), 32'd10);
        check("fast_idx", 32'(step_idx), 32'd0);
        step(3'd2, 10, p);
        check("skip_pulses", 32'(p), 32'd0);
        check("skip_err", 32'(err), 32'd1);
        check("skip_idx", 32'(step_idx), 32'd2);
        check("skip_stall", 32'(stall), 32'd1);
        cyc(8200, p);
        check("hold_stall", 32'(stall), 32'd1);
        check("hold_period", 32'(step_period), 32'd10);
        clear_err = 1'b1;
        cyc(1, p);
        clear_err = 1'b0;
        step(3'd6, 10, p);
        check("after_sat_pulses", 32'(p), 32'd1);
        check("after_sat_period", 32'(step_period), 32'd10);
        check("after_sat_idx", 32'(step_idx), 32'd3);
        check("after_sat_err", 32'(err), 32'd0);
        cyc(8170, p);
        check("sat_edge_run", 32'(stall), 32'd0);
        cyc(30, p);
        check("sat_edge_stall", 32'(stall), 32'd1);

        // Asynchronous reset during rotation.
        step(3'd4, 10, p);
        check("mid_pulses", 32'(p), 32'd1);
        check("mid_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(10, p);
        check("restart_pulses", 32'(p), 32'd0);
        check("restart_idx", 32'(step_idx), 32'd4);
        step(3'd5, 10, p);
        check("restart_step", 32'(p), 32'd1);
        check("restart_step_idx", 32'(step_idx), 32'd5);
        check("restart_stall", 32'(stall), 32'd0);

        check("no_double_pulse", 32'(doubles), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
